io_bus_bridge: RTL and testbench
================================

Name: io_bus_bridge

Overview:
- Parametrised successor to the fixed top-two-bits memory/I/O split. Sits between the processor's memory interface (memread/memwrite/adr/writedata/memdata) and two targets: external memory and a bank of NUM_CH memory-mapped I/O registers.
- Decodes each request, sequences memory wait states and I/O accesses through an FSM, and returns a ready pulse with registered read data.

Parameters:
- DATA_W, 16, data width of bus, memory and each I/O channel
- ADDR_W, 16, address width
- IO_TAG, 2'b11, value of adr[ADDR_W-1:ADDR_W-2] that selects I/O space
- NUM_CH, 4, number of I/O channels (1..16)
- MEM_LAT, 1, memory read/write latency in cycles (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- memread  in  1  CPU read request
- memwrite  in  1  CPU write request
- adr  in  ADDR_W  CPU address
- writedata  in  DATA_W  CPU write data
- memdata  out  DATA_W  read data returned to CPU
- ready  out  1  one-cycle completion pulse
- busy  out  1  high whenever FSM is not IDLE
- bus_err  out  1  one-cycle pulse, I/O access to nonexistent channel
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_adr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- io_in  in  NUM_CH*DATA_W  I/O input values, channel k at [k*DATA_W +: DATA_W]
- io_out  out  NUM_CH*DATA_W  I/O output registers, same packing
- io_wr  out  NUM_CH  one-cycle write strobe per channel

Behaviour:
- One clock domain. Reset is synchronous and active-high on port rst. All outputs, io_out registers and the FSM clear to 0/IDLE. Asserting rst mid-access aborts it: no ready, no io_wr, no further mem_en.
- FSM states: IDLE, MEM, DONE.
- Requests are sampled only in IDLE and ignored in other states. On acceptance, adr, writedata and direction are captured.
- memwrite and memread both high: the access is a write; the read is dropped.
- Decode: adr top two bits == IO_TAG selects I/O. Channel index = adr[3:0]. Anything else is memory.
- I/O write (request accepted in cycle N):
  - FSM goes to DONE.
  - In cycle N+1, io_out[ch] holds writedata, io_wr[ch]=1 and ready=1.
- I/O read: DONE in N+1. memdata = io_in[ch] as sampled at the N clock edge. ready=1.
- Channel index >= NUM_CH: a write is dropped and a read returns 0. ready=1 and bus_err=1 in N+1.
- Memory access:
  - FSM enters MEM for MEM_LAT cycles (N+1 .. N+MEM_LAT), counted down by an internal counter.
  - In MEM: mem_en=1, mem_we = captured write flag, mem_adr and mem_wdata from captured values.
  - On the last MEM cycle, mem_rdata is registered into memdata (reads only).
  - DONE at N+MEM_LAT+1 with ready=1.
- DONE always returns to IDLE next cycle. Back-to-back requests are therefore accepted at most every 2 cycles (I/O) or MEM_LAT+2 cycles (memory).
- memdata holds its value until the next read completes; writes do not change it.
- mem_en, mem_we and io_wr are 0 outside the states above. busy = (state != IDLE).

Optional Feature:
- IO_SYNC_EN defined: each io_in channel passes through a two-flop synchroniser (reset to 0) before use. I/O read returns the value io_in had 2 cycles before the N edge.
- Undefined: io_in is sampled directly.

Decomposition:
- Shared package io_bus_pkg: state encoding (IDLE/MEM/DONE), default IO_TAG, channel-index field width constant.
- One sub-module, io_reg_bank: holds NUM_CH io_out registers, the write strobes, the read mux and the optional synchroniser. The FSM, decode and memory sequencing stay in io_bus_bridge.

Test Plan:
- Reset: hold rst 2 cycles mid memory access -> ready, mem_en and io_out all 0, busy=0 after the reset edge.
- I/O write: adr=16'hC002, writedata=16'hBEEF, memwrite=1 at N -> N+1: io_out ch2=16'hBEEF, io_wr=4'b0100, ready=1. No mem_en at any point.
- I/O read: io_in ch1=16'h1234, adr=16'hC001, memread=1 -> ready at N+1 with memdata=16'h1234 (N+3 relative value with IO_SYNC_EN).
- Memory read, MEM_LAT=3: adr=16'h0040, memread=1 -> mem_en high cycles N+1..N+3, ready at N+4 with memdata equal to mem_rdata at N+3.
- Bad channel, NUM_CH=4: memread at adr=16'hC009 -> ready=1, bus_err=1, memdata=0. A write to the same address leaves io_out unchanged.
- Simultaneous memread+memwrite at adr=16'h0010: mem_we=1 during MEM and memdata unchanged. A second request raised while busy is ignored.

Source files
------------

// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared types and constants for io_bus_bridge
// Contents: FSM state encoding, default I/O space tag, channel-index width.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Top two address bits that select I/O space unless overridden.
    localparam logic [1:0] IO_TAG_DEFAULT = 2'b11;

    // Channel index lives in adr[3:0].
    localparam int CH_IDX_W = 4;

endpackage

// File: rtl/io_reg_bank.sv
// rtl/io_reg_bank.sv - memory-mapped I/O register bank for io_bus_bridge
// Optional macro: IO_SYNC_EN (two-flop synchroniser on every io_in channel).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wr_en        write request for the addressed channel (ignored if channel absent)
//   idx          channel index
//   wr_data      data written into the addressed io_out register
//   io_in        packed channel inputs, channel k at [k*DATA_W +: DATA_W]
//   rd_data      combinational read of the addressed channel, 0 if absent
//   ch_ok        addressed channel exists
//   io_out       packed output registers, same packing as io_in
//   io_wr        one-cycle write strobe per channel, aligned with io_out update
module io_reg_bank
    import io_bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [CH_IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_CH*DATA_W-1:0]   io_in,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       ch_ok,
    output logic [NUM_CH*DATA_W-1:0]   io_out,
    output logic [NUM_CH-1:0]          io_wr
);

    logic [NUM_CH*DATA_W-1:0] src;

`ifdef IO_SYNC_EN
    logic [NUM_CH*DATA_W-1:0] sync1;
    logic [NUM_CH*DATA_W-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
        end
    end

    assign src = sync2;
`else
    assign src = io_in;
`endif

    assign ch_ok = (int'(idx) < NUM_CH);

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == CH_IDX_W'(k)) begin
                rd_data = src[k*DATA_W +: DATA_W];
            end
        end
    end

    // Strobe is registered together with the data so both appear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_out <= '0;
            io_wr  <= '0;
        end else begin
            io_wr <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en && ch_ok && idx == CH_IDX_W'(k)) begin
                    io_out[k*DATA_W +: DATA_W] <= wr_data;
                    io_wr[k]                   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/io_bus_bridge.sv
// rtl/io_bus_bridge.sv - CPU bus bridge splitting accesses between memory and I/O registers
// Optional macro: IO_SYNC_EN (synchronised io_in, handled inside io_reg_bank).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   memread, memwrite         CPU request (both high = write)
//   adr, writedata            CPU address and write data
//   memdata                   registered read data, held until the next read completes
//   ready                     one-cycle completion pulse
//   busy                      FSM not idle
//   bus_err                   one-cycle pulse on access to a nonexistent I/O channel
//   mem_en, mem_we            memory enable / write enable, high only in MEM
//   mem_adr, mem_wdata        captured memory address / write data
//   mem_rdata                 memory read data
//   io_in, io_out, io_wr      I/O channel inputs, output registers, write strobes
module io_bus_bridge
    import io_bus_pkg::*;
#(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 16,
    parameter logic [1:0]  IO_TAG  = IO_TAG_DEFAULT,
    parameter int          NUM_CH  = 4,
    parameter int          MEM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       memread,
    input  logic                       memwrite,
    input  logic [ADDR_W-1:0]          adr,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          memdata,
    output logic                       ready,
    output logic                       busy,
    output logic                       bus_err,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_adr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic [NUM_CH*DATA_W-1:0]   io_in,
    output logic [NUM_CH*DATA_W-1:0]   io_out,
    output logic [NUM_CH-1:0]          io_wr
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                wr_q;
    logic                req;
    logic                is_io;
    logic                bank_wr_en;
    logic                ch_ok;
    logic [DATA_W-1:0]   bank_rdata;

    assign req   = memread | memwrite;
    assign is_io = (adr[ADDR_W-1 -: 2] == IO_TAG);
    assign busy  = (state != IDLE);

    // The bank commits the write on the acceptance edge, so io_out and io_wr
    // are visible in the DONE cycle together with ready.
    assign bank_wr_en = (state == IDLE) && memwrite && is_io;

    io_reg_bank #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_wr_en),
        .idx     (adr[CH_IDX_W-1:0]),
        .wr_data (writedata),
        .io_in   (io_in),
        .rd_data (bank_rdata),
        .ch_ok   (ch_ok),
        .io_out  (io_out),
        .io_wr   (io_wr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            memdata   <= '0;
            ready     <= 1'b0;
            bus_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
        end else begin
            ready   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        // A simultaneous read+write is treated as a write.
                        wr_q <= memwrite;
                        if (is_io) begin
                            state   <= DONE;
                            ready   <= 1'b1;
                            bus_err <= ~ch_ok;
                            if (!memwrite) begin
                                memdata <= bank_rdata;
                            end
                        end else begin
                            state     <= MEM;
                            cnt       <= CNT_W'(MEM_LAT - 1);
                            mem_en    <= 1'b1;
                            mem_we    <= memwrite;
                            mem_adr   <= adr;
                            mem_wdata <= writedata;
                        end
                    end
                end
                MEM: begin
                    if (cnt == '0) begin
                        state  <= DONE;
                        ready  <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (!wr_q) begin
                            memdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// tb/tb_io_bus_bridge.sv - self-checking bench for io_bus_bridge
module tb_io_bus_bridge;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int NCH  = 4;
    localparam int LAT  = 3;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            memread = 1'b0;
    logic            memwrite = 1'b0;
    logic [AW-1:0]   adr = '0;
    logic [DW-1:0]   writedata = '0;
    logic [DW-1:0]   mem_rdata = '0;
    logic [NCH*DW-1:0] io_in = '0;
    logic [DW-1:0]   memdata;
    logic            ready;
    logic            busy;
    logic            bus_err;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_adr;
    logic [DW-1:0]   mem_wdata;
    logic [NCH*DW-1:0] io_out;
    logic [NCH-1:0]  io_wr;

    io_bus_bridge #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .IO_TAG  (2'b11),
        .NUM_CH  (NCH),
        .MEM_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata),
        .ready     (ready),
        .busy      (busy),
        .bus_err   (bus_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_wr     (io_wr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Per-cycle input tables and expected-output timeline.
    bit [NCH*DW-1:0] io_tbl [MAXC];
    bit [DW-1:0]     mem_tbl [MAXC];
    bit              ready_e [MAXC];
    bit              err_e [MAXC];
    bit              busy_e [MAXC];
    bit              men_e [MAXC];
    bit              mwe_e [MAXC];
    bit [AW-1:0]     madr_e [MAXC];
    bit [DW-1:0]     mwd_e [MAXC];
    bit [NCH-1:0]    iowr_e [MAXC];
    bit              mdupd [MAXC];
    bit [DW-1:0]     mdval [MAXC];
    bit              ioupd [MAXC];
    int              iochan [MAXC];
    bit [DW-1:0]     iodat [MAXC];
    bit              rstz [MAXC];

    int              next_accept = 0;
    bit [DW-1:0]     m_memdata = '0;
    bit [NCH*DW-1:0] m_io = '0;
`ifdef IO_SYNC_EN
    bit [NCH*DW-1:0] s1 = '0;
    bit [NCH*DW-1:0] s2 = '0;
    bit              prev_rst = 1'b1;
    bit [NCH*DW-1:0] prev_io = '0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: on acceptance, schedule every output effect on the timeline.
    task automatic model(input bit r, input bit rd, input bit wr, input bit [AW-1:0] a, input bit [DW-1:0] d);
        bit [NCH*DW-1:0] src;
        int ch;
        bit ok;
`ifdef IO_SYNC_EN
        if (prev_rst) begin
            s1 = '0;
            s2 = '0;
        end else begin
            s2 = s1;
            s1 = prev_io;
        end
        src      = s2;
        prev_rst = r;
        prev_io  = io_tbl[cyc];
`else
        src = io_tbl[cyc];
`endif
        if (r) begin
            for (int c = cyc + 1; c <= cyc + LAT + 3; c++) begin
                ready_e[c] = 0; err_e[c] = 0; busy_e[c] = 0; men_e[c] = 0;
                mwe_e[c] = 0; iowr_e[c] = '0; mdupd[c] = 0; ioupd[c] = 0;
            end
            rstz[cyc+1] = 1;
            next_accept = cyc + 1;
        end else if ((rd || wr) && cyc >= next_accept) begin
            ch = int'(a[3:0]);
            ok = (ch < NCH);
            if (a[15:14] == 2'b11) begin
                ready_e[cyc+1] = 1;
                busy_e[cyc+1]  = 1;
                err_e[cyc+1]   = !ok;
                if (wr && ok) begin
                    iowr_e[cyc+1] = NCH'(1 << ch);
                    ioupd[cyc+1]  = 1;
                    iochan[cyc+1] = ch;
                    iodat[cyc+1]  = d;
                end
                if (!wr) begin
                    mdupd[cyc+1] = 1;
                    mdval[cyc+1] = ok ? src[ch*DW +: DW] : '0;
                end
                next_accept = cyc + 2;
            end else begin
                for (int k = 1; k <= LAT; k++) begin
                    men_e[cyc+k]  = 1;
                    mwe_e[cyc+k]  = wr;
                    madr_e[cyc+k] = a;
                    mwd_e[cyc+k]  = d;
                    busy_e[cyc+k] = 1;
                end
                ready_e[cyc+LAT+1] = 1;
                busy_e[cyc+LAT+1]  = 1;
                if (!wr) begin
                    mdupd[cyc+LAT+1] = 1;
                    mdval[cyc+LAT+1] = mem_tbl[cyc+LAT];
                end
                next_accept = cyc + LAT + 2;
            end
        end
    endtask

    task automatic drive(input bit r, input bit rd, input bit wr, input bit [AW-1:0] a, input bit [DW-1:0] d);
        @(posedge clk);
        #1;
        cyc++;
        rst       = r;
        memread   = rd;
        memwrite  = wr;
        adr       = a;
        writedata = d;
        io_in     = io_tbl[cyc];
        mem_rdata = mem_tbl[cyc];
        model(r, rd, wr, a, d);
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, '0);
    endtask

    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (rstz[cyc]) begin
                m_memdata = '0;
                m_io      = '0;
            end
            if (mdupd[cyc]) m_memdata = mdval[cyc];
            if (ioupd[cyc]) m_io[iochan[cyc]*DW +: DW] = iodat[cyc];
            chk("ready", ready, ready_e[cyc]);
            chk("bus_err", bus_err, err_e[cyc]);
            chk("busy", busy, busy_e[cyc]);
            chk("mem_en", mem_en, men_e[cyc]);
            chk("mem_we", mem_we, mwe_e[cyc]);
            chk("io_wr", io_wr, iowr_e[cyc]);
            chk("memdata", memdata, m_memdata);
            chk("io_out", io_out, m_io);
            if (men_e[cyc]) begin
                chk("mem_adr", mem_adr, madr_e[cyc]);
                chk("mem_wdata", mem_wdata, mwd_e[cyc]);
            end
        end
    end

    initial begin
        bit r, rd, wr;
        bit [AW-1:0] a;
        for (int i = 0; i < MAXC; i++) begin
            io_tbl[i]  = {$urandom, $urandom};
            mem_tbl[i] = DW'($urandom);
        end

        // Reset state
        drive(1, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        idle();
        chk("lit_reset_busy", busy, 1'b0);
        chk("lit_reset_io_out", io_out, 64'h0);

        // I/O write
        drive(0, 0, 1, 16'hC002, 16'hBEEF);
        idle();
        chk("lit_iow_data", io_out[47:32], 16'hBEEF);
        chk("lit_iow_strobe", io_wr, 4'b0100);
        chk("lit_iow_ready", ready, 1'b1);
        idle();

        // I/O read of channel 1
        for (int c = cyc + 1; c <= cyc + 5; c++) io_tbl[c][31:16] = 16'h1234;
        idle();
        idle();
        drive(0, 1, 0, 16'hC001, '0);
        idle();
        chk("lit_ior_ready", ready, 1'b1);
        chk("lit_ior_data", memdata, 16'h1234);
        idle();

        // Memory read, three wait cycles
        mem_tbl[cyc+4] = 16'hA5C3;
        drive(0, 1, 0, 16'h0040, '0);
        for (int k = 0; k < LAT; k++) begin
            idle();
            chk("lit_memr_en", mem_en, 1'b1);
            chk("lit_memr_adr", mem_adr, 16'h0040);
        end
        idle();
        chk("lit_memr_ready", ready, 1'b1);
        chk("lit_memr_data", memdata, 16'hA5C3);
        idle();

        // Nonexistent channel
        drive(0, 1, 0, 16'hC009, '0);
        idle();
        chk("lit_bad_ready", ready, 1'b1);
        chk("lit_bad_err", bus_err, 1'b1);
        chk("lit_bad_data", memdata, 16'h0);
        idle();
        drive(0, 0, 1, 16'hC009, 16'h5555);
        idle();
        chk("lit_badw_err", bus_err, 1'b1);
        chk("lit_badw_iowr", io_wr, 4'b0000);
        chk("lit_badw_io_out", io_out, 64'h0000_BEEF_0000_0000);
        idle();

        // Read+write together, with a request raised while busy
        drive(0, 1, 1, 16'h0010, 16'h7777);
        drive(0, 1, 0, 16'hC001, '0);
        chk("lit_rw_we", mem_we, 1'b1);
        idle();
        idle();
        idle();
        chk("lit_rw_ready", ready, 1'b1);
        chk("lit_rw_memdata", memdata, 16'h0);
        idle();
        chk("lit_rw_no_extra", ready, 1'b0);
        idle();

        // Reset in the middle of a memory access
        drive(0, 1, 0, 16'h0040, '0);
        drive(1, 0, 0, '0, '0);
        chk("lit_rst_mem_en_before", mem_en, 1'b1);
        drive(1, 0, 0, '0, '0);
        idle();
        chk("lit_rst_ready", ready, 1'b0);
        chk("lit_rst_mem_en", mem_en, 1'b0);
        chk("lit_rst_io_out", io_out, 64'h0);
        chk("lit_rst_busy", busy, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                a = {2'b11, 10'($urandom), 4'($urandom)};
            else
                a = {2'($urandom_range(0, 2)), 14'($urandom)};
            drive(r, rd, wr, a, DW'($urandom));
        end
        for (int i = 0; i < LAT + 3; i++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
